// File: rtl/exc_commit_ctrl_pkg.sv
// Package: exc_pkg
// Shared types, exception code constants and code-classification helpers
// for the exception/ERET commit controller.
//   word_t       : 32-bit datapath word
//   exc_state_e  : controller FSM states (IDLE, COMMIT, DRAIN, REDIRECT)
//   EXC_*        : priority encoder output codes
//   EXC_VECTOR_DEFAULT : general exception entry PC
package exc_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } exc_state_e;

  localparam word_t EXC_INT  = 32'h0000_0001;
  localparam word_t EXC_ADEL = 32'h0000_0004;
  localparam word_t EXC_ADES = 32'h0000_0005;
  localparam word_t EXC_SYS  = 32'h0000_0008;
  localparam word_t EXC_BP   = 32'h0000_0009;
  localparam word_t EXC_RI   = 32'h0000_000A;
  localparam word_t EXC_OV   = 32'h0000_000C;
  localparam word_t EXC_TR   = 32'h0000_000D;
  localparam word_t EXC_ERET = 32'h0000_000E;

  localparam word_t EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // True for codes that enter the exception vector (ERET is not one of them).
  function automatic logic is_exc_code(input word_t code);
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV, EXC_TR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Address errors are the only codes that also record BadVAddr.
  function automatic logic is_badvaddr_code(input word_t code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Interface: exc_commit_ctrl_if
// Bundles the commit-stage event inputs, CP0 update outputs, pipeline
// control outputs and the fetch redirect handshake.
//   master : commit stage / CP0 / fetch side (drives *_i, observes *_o)
//   slave  : exc_commit_ctrl (observes *_i, drives *_o)
interface exc_commit_ctrl_if;
  import exc_pkg::*;

  word_t       exc_code_i;
  logic        exc_valid_i;
  word_t       exc_pc_i;
  logic        exc_bd_i;
  word_t       exc_badvaddr_i;
  logic        cp0_status_exl_i;
  word_t       cp0_epc_i;
  logic        mem_busy_i;
  logic        redirect_ready_i;

  logic        flush_o;
  logic        stall_o;
  logic        cp0_exc_we_o;
  logic        cp0_epc_we_o;
  word_t       cp0_epc_o;
  logic        cp0_bd_o;
  logic [4:0]  cp0_exccode_o;
  logic        cp0_badvaddr_we_o;
  word_t       cp0_badvaddr_o;
  logic        cp0_eret_o;
  logic        redirect_valid_o;
  word_t       redirect_pc_o;

  modport master (
    output exc_code_i, exc_valid_i, exc_pc_i, exc_bd_i, exc_badvaddr_i,
           cp0_status_exl_i, cp0_epc_i, mem_busy_i, redirect_ready_i,
    input  flush_o, stall_o, cp0_exc_we_o, cp0_epc_we_o, cp0_epc_o,
           cp0_bd_o, cp0_exccode_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
           cp0_eret_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  exc_code_i, exc_valid_i, exc_pc_i, exc_bd_i, exc_badvaddr_i,
           cp0_status_exl_i, cp0_epc_i, mem_busy_i, redirect_ready_i,
    output flush_o, stall_o, cp0_exc_we_o, cp0_epc_we_o, cp0_epc_o,
           cp0_bd_o, cp0_exccode_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
           cp0_eret_o, redirect_valid_o, redirect_pc_o
  );

endinterface

// File: rtl/exc_commit_ctrl.sv
// Module: exc_commit_ctrl
// Sequences exception entry and ERET from the commit stage: latches the
// event context, pulses the CP0 update strobes for one cycle, holds a
// pipeline flush while data-memory traffic drains, then presents the
// redirect PC to fetch over a valid/ready handshake.
// Ports:
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   bus         : exc_commit_ctrl_if.slave (event in, CP0/flush/redirect out)
//   exc_count_o : exception entry count (only with EXC_COMMIT_CTRL_PERF_CNT_EN)
// Parameters:
//   EXC_VECTOR  : general exception entry PC
//   ERET_CODE   : encoder value meaning ERET
// Build option:
//   EXC_COMMIT_CTRL_PERF_CNT_EN : adds the wrapping 32-bit exception counter
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter word_t ERET_CODE  = EXC_ERET
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  exc_commit_ctrl_if.slave     bus
`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
  , output logic [31:0]        exc_count_o
`endif
);

  exc_state_e state_q;
  logic       eret_q;
  word_t      eret_target_q;

  logic       flush_q;
  logic       stall_q;
  logic       exc_we_q;
  logic       epc_we_q;
  word_t      epc_q;
  logic       bd_q;
  logic [4:0] exccode_q;
  logic       badvaddr_we_q;
  word_t      badvaddr_q;
  logic       eret_pulse_q;
  logic       redirect_valid_q;
  word_t      redirect_pc_q;

  logic       in_is_exc;
  logic       in_is_eret;

  assign in_is_exc  = is_exc_code(bus.exc_code_i);
  assign in_is_eret = (bus.exc_code_i == ERET_CODE);

  // Single FSM with registered outputs. The CP0 value/strobe registers are
  // loaded on the accept edge so they are visible during COMMIT and are
  // cleared on leaving COMMIT, giving one-cycle pulses. The EPC target for
  // ERET is captured at accept time so later CP0 writes cannot move it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      eret_q           <= 1'b0;
      eret_target_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      exc_we_q         <= 1'b0;
      epc_we_q         <= 1'b0;
      epc_q            <= '0;
      bd_q             <= 1'b0;
      exccode_q        <= '0;
      badvaddr_we_q    <= 1'b0;
      badvaddr_q       <= '0;
      eret_pulse_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.exc_valid_i && (in_is_exc || in_is_eret)) begin
            state_q       <= COMMIT;
            flush_q       <= 1'b1;
            stall_q       <= 1'b1;
            eret_q        <= in_is_eret;
            eret_target_q <= bus.cp0_epc_i;
            if (in_is_eret) begin
              eret_pulse_q <= 1'b1;
            end else begin
              exc_we_q  <= 1'b1;
              exccode_q <= bus.exc_code_i[4:0];
              // Nested exception: EPC and BD keep the outer handler's values.
              if (!bus.cp0_status_exl_i) begin
                epc_we_q <= 1'b1;
                epc_q    <= bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                bd_q     <= bus.exc_bd_i;
              end
              if (is_badvaddr_code(bus.exc_code_i)) begin
                badvaddr_we_q <= 1'b1;
                badvaddr_q    <= bus.exc_badvaddr_i;
              end
            end
          end
        end
        COMMIT: begin
          state_q       <= DRAIN;
          exc_we_q      <= 1'b0;
          epc_we_q      <= 1'b0;
          epc_q         <= '0;
          bd_q          <= 1'b0;
          exccode_q     <= '0;
          badvaddr_we_q <= 1'b0;
          badvaddr_q    <= '0;
          eret_pulse_q  <= 1'b0;
        end
        DRAIN: begin
          if (!bus.mem_busy_i) begin
            state_q          <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= eret_q ? eret_target_q : EXC_VECTOR;
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready_i) begin
            state_q          <= IDLE;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            eret_q           <= 1'b0;
            eret_target_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
  // Counts exception entries (ERET excluded), once per COMMIT cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_count_o <= '0;
    end else if (state_q == COMMIT && !eret_q) begin
      exc_count_o <= exc_count_o + 32'd1;
    end
  end
`else
  // No exception counter in this build.
`endif

  assign bus.flush_o           = flush_q;
  assign bus.stall_o           = stall_q;
  assign bus.cp0_exc_we_o      = exc_we_q;
  assign bus.cp0_epc_we_o      = epc_we_q;
  assign bus.cp0_epc_o         = epc_q;
  assign bus.cp0_bd_o          = bd_q;
  assign bus.cp0_exccode_o     = exccode_q;
  assign bus.cp0_badvaddr_we_o = badvaddr_we_q;
  assign bus.cp0_badvaddr_o    = badvaddr_q;
  assign bus.cp0_eret_o        = eret_pulse_q;
  assign bus.redirect_valid_o  = redirect_valid_q;
  assign bus.redirect_pc_o     = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Testbench: tb_exc_commit_ctrl
// Directed scenarios for exc_commit_ctrl with hand-computed expectations:
// reset, syscall, AdEL in a delay slot, nested overflow, ERET, long drain
// with back-pressured redirect, and asynchronous reset mid-sequence.
// Build option: EXC_COMMIT_CTRL_PERF_CNT_EN enables exception counter checks.
module tb_exc_commit_ctrl;
  import exc_pkg::*;

  logic clk_i;
  logic rst_i;
  int   tests_run;
  int   tests_failed;

  exc_commit_ctrl_if bus();

`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
  logic [31:0] exc_count_o;
`endif

  exc_commit_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
    , .exc_count_o (exc_count_o)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Return all event inputs to an idle, no-event pattern.
  task automatic clear_inputs();
    bus.exc_code_i       = '0;
    bus.exc_valid_i      = 1'b0;
    bus.exc_pc_i         = '0;
    bus.exc_bd_i         = 1'b0;
    bus.exc_badvaddr_i   = '0;
    bus.cp0_status_exl_i = 1'b0;
    bus.cp0_epc_i        = '0;
    bus.mem_busy_i       = 1'b0;
    bus.redirect_ready_i = 1'b0;
  endtask

  // Present one commit-stage event for the next edge.
  task automatic drive_event(input word_t code, input word_t pc, input logic bd,
                             input word_t badvaddr, input logic exl, input word_t epc);
    bus.exc_valid_i      = 1'b1;
    bus.exc_code_i       = code;
    bus.exc_pc_i         = pc;
    bus.exc_bd_i         = bd;
    bus.exc_badvaddr_i   = badvaddr;
    bus.cp0_status_exl_i = exl;
    bus.cp0_epc_i        = epc;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flush_stall: got %b/%b expected 0/0", bus.flush_o, bus.stall_o);
    end
    tests_run++;
    if (bus.redirect_valid_o !== 1'b0 || bus.redirect_pc_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_redirect: got %b/%h expected 0/00000000",
               bus.redirect_valid_o, bus.redirect_pc_o);
    end
    tests_run++;
    if ({bus.cp0_exc_we_o, bus.cp0_epc_we_o, bus.cp0_badvaddr_we_o, bus.cp0_eret_o} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000",
               {bus.cp0_exc_we_o, bus.cp0_epc_we_o, bus.cp0_badvaddr_we_o, bus.cp0_eret_o});
    end
`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
    tests_run++;
    if (exc_count_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %h expected 00000000", exc_count_o);
    end
`endif
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_no_event();
    // Invalid nonzero code with valid, then a real code without valid.
    drive_event(32'h2, 32'h8000_0000, 1'b0, '0, 1'b0, '0);
    tick();
    bus.exc_code_i  = 32'h8;
    bus.exc_valid_i = 1'b0;
    tick();
    tests_run++;
    if (bus.flush_o !== 1'b0 || bus.cp0_exc_we_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_event: got flush %b exc_we %b expected 0/0",
               bus.flush_o, bus.cp0_exc_we_o);
    end
    clear_inputs();
  endtask

  task automatic test_syscall();
    drive_event(32'h8, 32'h8000_1000, 1'b0, 32'h1234_5678, 1'b0, 32'h0);
    tick();
    clear_inputs();
    tests_run++;
    if (bus.cp0_exc_we_o !== 1'b1 || bus.cp0_epc_we_o !== 1'b1 || bus.cp0_epc_o !== 32'h8000_1000
        || bus.cp0_exccode_o !== 5'd8 || bus.cp0_badvaddr_we_o !== 1'b0 || bus.flush_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sys_commit: got exc_we %b epc_we %b epc %h code %h bv_we %b flush %b expected 1 1 80001000 08 0 1",
               bus.cp0_exc_we_o, bus.cp0_epc_we_o, bus.cp0_epc_o, bus.cp0_exccode_o,
               bus.cp0_badvaddr_we_o, bus.flush_o);
    end
    tick();
    tests_run++;
    if (bus.cp0_exc_we_o !== 1'b0 || bus.redirect_valid_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sys_drain: got exc_we %b rv %b stall %b expected 0 0 1",
               bus.cp0_exc_we_o, bus.redirect_valid_o, bus.stall_o);
    end
    tick();
    tests_run++;
    if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'hBFC0_0380) begin
      tests_failed++;
      $display("[TB] FAIL sys_redirect: got %b/%h expected 1/bfc00380",
               bus.redirect_valid_o, bus.redirect_pc_o);
    end
    bus.redirect_ready_i = 1'b1;
    tick();
    bus.redirect_ready_i = 1'b0;
    tests_run++;
    if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sys_idle: got rv %b flush %b expected 0/0", bus.redirect_valid_o, bus.flush_o);
    end
  endtask

  task automatic test_adel_bd();
    drive_event(32'h4, 32'h8000_2004, 1'b1, 32'h0000_0003, 1'b0, 32'h0);
    tick();
    clear_inputs();
    tests_run++;
    if (bus.cp0_epc_o !== 32'h8000_2000 || bus.cp0_bd_o !== 1'b1 || bus.cp0_exccode_o !== 5'd4
        || bus.cp0_badvaddr_we_o !== 1'b1 || bus.cp0_badvaddr_o !== 32'h0000_0003) begin
      tests_failed++;
      $display("[TB] FAIL adel_commit: got epc %h bd %b code %h bv_we %b bv %h expected 80002000 1 04 1 00000003",
               bus.cp0_epc_o, bus.cp0_bd_o, bus.cp0_exccode_o, bus.cp0_badvaddr_we_o, bus.cp0_badvaddr_o);
    end
    tick();
    tick();
    bus.redirect_ready_i = 1'b1;
    tick();
    bus.redirect_ready_i = 1'b0;
  endtask

  task automatic test_ov_exl();
    drive_event(32'hC, 32'h8000_4000, 1'b1, 32'h0, 1'b1, 32'h0);
    tick();
    clear_inputs();
    tests_run++;
    if (bus.cp0_exc_we_o !== 1'b1 || bus.cp0_exccode_o !== 5'h0C || bus.cp0_epc_we_o !== 1'b0
        || bus.cp0_bd_o !== 1'b0 || bus.cp0_badvaddr_we_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ov_exl_commit: got exc_we %b code %h epc_we %b bd %b bv_we %b expected 1 0c 0 0 0",
               bus.cp0_exc_we_o, bus.cp0_exccode_o, bus.cp0_epc_we_o, bus.cp0_bd_o, bus.cp0_badvaddr_we_o);
    end
    tick();
    tick();
    tests_run++;
    if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'hBFC0_0380) begin
      tests_failed++;
      $display("[TB] FAIL ov_redirect: got %b/%h expected 1/bfc00380", bus.redirect_valid_o, bus.redirect_pc_o);
    end
    bus.redirect_ready_i = 1'b1;
    tick();
    bus.redirect_ready_i = 1'b0;
  endtask

  task automatic test_eret();
    drive_event(32'hE, 32'h8000_5000, 1'b0, 32'h0, 1'b1, 32'h8000_3000);
    tick();
    clear_inputs();
    bus.cp0_epc_i = 32'hDEAD_BEEF;
    tests_run++;
    if (bus.cp0_eret_o !== 1'b1 || bus.cp0_exc_we_o !== 1'b0 || bus.cp0_epc_we_o !== 1'b0
        || bus.cp0_badvaddr_we_o !== 1'b0 || bus.flush_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL eret_commit: got eret %b exc_we %b epc_we %b bv_we %b flush %b expected 1 0 0 0 1",
               bus.cp0_eret_o, bus.cp0_exc_we_o, bus.cp0_epc_we_o, bus.cp0_badvaddr_we_o, bus.flush_o);
    end
    tick();
    tests_run++;
    if (bus.cp0_eret_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL eret_pulse_width: got %b expected 0", bus.cp0_eret_o);
    end
    tick();
    tests_run++;
    if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h8000_3000) begin
      tests_failed++;
      $display("[TB] FAIL eret_redirect: got %b/%h expected 1/80003000", bus.redirect_valid_o, bus.redirect_pc_o);
    end
    bus.redirect_ready_i = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int drain_bad;
    int hold_bad;
    drain_bad = 0;
    hold_bad  = 0;
    bus.mem_busy_i = 1'b1;
    drive_event(32'h1, 32'h8000_6000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clear_inputs();
    bus.mem_busy_i = 1'b1;
    tick();
    // Five busy cycles in DRAIN with a syscall presented that must be ignored.
    drive_event(32'h8, 32'h8000_7000, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.mem_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.flush_o !== 1'b1 || bus.redirect_valid_o !== 1'b0 || bus.cp0_exc_we_o !== 1'b0) drain_bad++;
    end
    tests_run++;
    if (drain_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_hold: got %0d bad cycles expected 0", drain_bad);
    end
    bus.mem_busy_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.flush_o !== 1'b1 || bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'hBFC0_0380) hold_bad++;
    end
    tests_run++;
    if (hold_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_stable: got %0d bad cycles expected 0", hold_bad);
    end
    // Syscall still presented across the handshake: not taken on the handshake edge.
    bus.redirect_ready_i = 1'b1;
    tick();
    bus.redirect_ready_i = 1'b0;
    tests_run++;
    if (bus.flush_o !== 1'b0 || bus.redirect_valid_o !== 1'b0 || bus.cp0_exc_we_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL handshake_idle: got flush %b rv %b exc_we %b expected 0 0 0",
               bus.flush_o, bus.redirect_valid_o, bus.cp0_exc_we_o);
    end
    tick();
    clear_inputs();
    tests_run++;
    if (bus.cp0_exc_we_o !== 1'b1 || bus.cp0_epc_o !== 32'h8000_7000 || bus.cp0_exccode_o !== 5'd8) begin
      tests_failed++;
      $display("[TB] FAIL accept_after_idle: got exc_we %b epc %h code %h expected 1 80007000 08",
               bus.cp0_exc_we_o, bus.cp0_epc_o, bus.cp0_exccode_o);
    end
    tick();
    tick();
    bus.redirect_ready_i = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    bus.mem_busy_i = 1'b1;
    drive_event(32'h9, 32'h8000_8000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clear_inputs();
    bus.mem_busy_i = 1'b1;
    tick();
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_drain: got flush %b stall %b expected 0/0", bus.flush_o, bus.stall_o);
    end
    rst_i = 1'b0;
    clear_inputs();
    tick();
    drive_event(32'hD, 32'h8000_9000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (bus.redirect_valid_o !== 1'b0 || bus.redirect_pc_o !== 32'h0 || bus.flush_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_redirect: got rv %b pc %h flush %b expected 0 00000000 0",
               bus.redirect_valid_o, bus.redirect_pc_o, bus.flush_o);
    end
`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
    tests_run++;
    if (exc_count_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count_mid: got %h expected 00000000", exc_count_o);
    end
`endif
    rst_i = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got rv %b flush %b expected 0/0", bus.redirect_valid_o, bus.flush_o);
    end
  endtask

`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
  task automatic test_perf_count();
    // One exception and one ERET from a freshly reset counter: count is 1.
    drive_event(32'hA, 32'h8000_A000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    clear_inputs();
    tick();
    tick();
    bus.redirect_ready_i = 1'b1;
    tick();
    clear_inputs();
    drive_event(32'hE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0100);
    tick();
    clear_inputs();
    tick();
    tick();
    bus.redirect_ready_i = 1'b1;
    tick();
    clear_inputs();
    tests_run++;
    if (exc_count_o !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL perf_count: got %h expected 00000001", exc_count_o);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    clear_inputs();
    test_reset();
    test_no_event();
    test_syscall();
    test_adel_bd();
    test_ov_exl();
    test_eret();
    test_back_to_back();
    test_async_reset();
`ifdef EXC_COMMIT_CTRL_PERF_CNT_EN
    test_perf_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
